// File: rtl/serial_paralelo_sync_if.sv
// Serial link bundle between the line side (master) and the aligning receiver (slave).
// The master drives the serial bit stream and observes the recovered parallel words and status.
interface serial_paralelo_sync_if #(
   parameter int WIDTH = 8
);
   logic             data_out;
   logic [WIDTH-1:0] data_rx;
   logic             valid_rx;
   logic             active;
   logic             word_stb;

   modport master (
      output data_out,
      input  data_rx,
      input  valid_rx,
      input  active,
      input  word_stb
   );

   modport slave (
      input  data_out,
      output data_rx,
      output valid_rx,
      output active,
      output word_stb
   );
endinterface

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel receiver on the bit clock: hunts for a comma at any bit offset,
// locks the word boundary, then emits aligned words once enough commas have been seen.
module serial_paralelo_sync #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
   parameter int               LOCK_COUNT = 4,
   parameter bit               LSB_FIRST  = 1'b1
) (
   input logic                    clk_32f,
   input logic                    reset,
   serial_paralelo_sync_if.slave  link
);

   localparam int BW = $clog2(WIDTH);
   localparam int FW = $clog2(WIDTH + 1);
   localparam int CW = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {
      HUNT,
      ALIGN,
      ACTIVE
   } stateT;

   stateT            r_state;
   logic [WIDTH-1:0] r_shiftReg;
   logic [BW-1:0]    r_bitCnt;
   logic [FW-1:0]    r_fill;
   logic [CW-1:0]    r_commaCnt;
   logic [WIDTH-1:0] r_dataRx;
   logic             r_validRx;
   logic             r_active;
   logic             r_wordStb;

   logic [WIDTH-1:0] w_window;
   logic             w_fillDone;
   logic             w_isComma;
   logic             w_boundary;

   // The window already contains the bit sampled on this edge, so a word is judged
   // on the same edge that delivers its last bit.
   generate
      if (LSB_FIRST) begin : gLsbFirst
         assign w_window = {link.data_out, r_shiftReg[WIDTH-1:1]};
      end else begin : gMsbFirst
         assign w_window = {r_shiftReg[WIDTH-2:0], link.data_out};
      end
   endgenerate

   assign w_fillDone = (r_fill >= FW'(WIDTH - 1));
   assign w_isComma  = (w_window == COMMA);
   assign w_boundary = (r_bitCnt == BW'(WIDTH - 1));

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_state    <= HUNT;
         r_shiftReg <= '0;
         r_bitCnt   <= '0;
         r_fill     <= '0;
         r_commaCnt <= '0;
         r_dataRx   <= '0;
         r_validRx  <= 1'b0;
         r_active   <= 1'b0;
         r_wordStb  <= 1'b0;
      end else begin
         r_shiftReg <= w_window;
         r_validRx  <= 1'b0;
         r_wordStb  <= 1'b0;
         r_bitCnt   <= w_boundary ? '0 : r_bitCnt + 1'b1;
         if (r_fill != FW'(WIDTH)) begin
            r_fill <= r_fill + 1'b1;
         end

         case (r_state)
            HUNT: begin
               if (w_fillDone && w_isComma) begin
                  r_bitCnt   <= '0;
                  r_commaCnt <= CW'(1);
                  r_wordStb  <= 1'b1;
                  r_dataRx   <= w_window;
                  if (LOCK_COUNT == 1) begin
                     r_state  <= ACTIVE;
                     r_active <= 1'b1;
                  end else begin
                     r_state <= ALIGN;
                  end
               end
            end

            ALIGN: begin
               if (w_boundary) begin
                  r_wordStb <= 1'b1;
                  r_dataRx  <= w_window;
                  if (w_isComma) begin
                     if (int'(r_commaCnt) + 1 >= LOCK_COUNT) begin
                        r_commaCnt <= CW'(LOCK_COUNT);
                        r_state    <= ACTIVE;
                        r_active   <= 1'b1;
                     end else begin
                        r_commaCnt <= r_commaCnt + 1'b1;
                     end
                  end else begin
                     // A misaligned or corrupted word drops the lock attempt entirely.
                     r_commaCnt <= '0;
                     r_state    <= HUNT;
                  end
               end
            end

            ACTIVE: begin
               if (w_boundary) begin
                  r_wordStb <= 1'b1;
                  r_dataRx  <= w_window;
                  r_validRx <= !w_isComma;
               end
            end

            default: r_state <= HUNT;
         endcase
      end
   end

   assign link.data_rx  = r_dataRx;
   assign link.valid_rx = r_validRx;
   assign link.active   = r_active;
   assign link.word_stb = r_wordStb;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync: an 8-bit LSB-first instance and a 10-bit MSB-first
// instance, with expected boundary words queued as bits are driven and popped on word_stb.
module tb_serial_paralelo_sync;

   typedef struct {
      logic [15:0] data;
      logic        valid;
      logic        active;
   } expT;

   logic clk;
   logic rstA;
   logic rstB;
   int   errors;
   int   checks;
   expT  sbq[$];

   serial_paralelo_sync_if #(.WIDTH(8))  ifA ();
   serial_paralelo_sync_if #(.WIDTH(10)) ifB ();

   serial_paralelo_sync #(
      .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LSB_FIRST(1'b1)
   ) dutA (
      .clk_32f(clk),
      .reset(rstA),
      .link(ifA)
   );

   serial_paralelo_sync #(
      .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2), .LSB_FIRST(1'b0)
   ) dutB (
      .clk_32f(clk),
      .reset(rstB),
      .link(ifB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives nBits of a word, checking word_stb on every edge and popping the queued
   // expectation whenever the DUT strobes.
   task automatic applyStimulus(input bit sel, input logic [15:0] word, input int nBits,
                                input bit msbFirst, input bit stbAtEnd,
                                input logic [15:0] expData, input bit expValid,
                                input bit expActive);
      expT         e;
      logic        b;
      logic        obsStb;
      logic        obsValid;
      logic        obsActive;
      logic [15:0] obsData;
      if (stbAtEnd) begin
         e.data   = expData;
         e.valid  = expValid;
         e.active = expActive;
         sbq.push_back(e);
      end
      for (int i = 0; i < nBits; i++) begin
         b = msbFirst ? word[nBits-1-i] : word[i];
         if (sel) ifB.data_out = b;
         else     ifA.data_out = b;
         @(posedge clk);
         #1;
         obsStb    = sel ? ifB.word_stb : ifA.word_stb;
         obsValid  = sel ? ifB.valid_rx : ifA.valid_rx;
         obsActive = sel ? ifB.active   : ifA.active;
         obsData   = sel ? 16'(ifB.data_rx) : 16'(ifA.data_rx);
         checkOutput("word_stb", 16'(obsStb), 16'(stbAtEnd && (i == nBits - 1)));
         if (obsStb === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("data_rx", obsData, e.data);
            checkOutput("valid_rx", 16'(obsValid), 16'(e.valid));
            checkOutput("active", 16'(obsActive), 16'(e.active));
         end else begin
            checkOutput("valid_idle", 16'(obsValid), 16'h0);
         end
      end
   endtask

   task automatic resetA();
      rstA = 1'b0;
      ifA.data_out = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_data", 16'(ifA.data_rx), 16'h0);
      checkOutput("rst_active", 16'(ifA.active), 16'h0);
      checkOutput("rst_stb", 16'(ifA.word_stb), 16'h0);
      rstA = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rstA = 1'b0;
      rstB = 1'b0;
      ifA.data_out = 1'b0;
      ifB.data_out = 1'b0;

      // Idle zeros after reset must never produce a strobe or lock.
      resetA();
      applyStimulus(1'b0, 16'h0000, 20, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("t1_data", 16'(ifA.data_rx), 16'h0);
      checkOutput("t1_active", 16'(ifA.active), 16'h0);

      // Three garbage bits, then five commas and a data word.
      resetA();
      applyStimulus(1'b0, 16'h0005, 3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h0055, 8, 1'b0, 1'b1, 16'h0055, 1'b1, 1'b1);

      // A non-comma while aligning drops back to hunting; relock needs four fresh commas.
      resetA();
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0012, 8, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h00A7, 8, 1'b0, 1'b1, 16'h00A7, 1'b1, 1'b1);

      // Reset pulse mid-word clears outputs immediately, before any clock edge.
      applyStimulus(1'b0, 16'h0007, 3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      #2;
      rstA = 1'b0;
      #1;
      checkOutput("async_data", 16'(ifA.data_rx), 16'h0);
      checkOutput("async_active", 16'(ifA.active), 16'h0);
      checkOutput("async_valid", 16'(ifA.valid_rx), 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstA = 1'b1;
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b1);

      // Long idle run on a locked link: strobes every word, never valid, stays active.
      for (int n = 0; n < 100; n++) begin
         applyStimulus(1'b0, 16'h00BC, 8, 1'b0, 1'b1, 16'h00BC, 1'b0, 1'b1);
      end

      // 10-bit MSB-first instance with a lock count of two.
      #2;
      rstB = 1'b1;
      applyStimulus(1'b1, 16'h017C, 10, 1'b1, 1'b1, 16'h017C, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h017C, 10, 1'b1, 1'b1, 16'h017C, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'h02A5, 10, 1'b1, 1'b1, 16'h02A5, 1'b1, 1'b1);
      applyStimulus(1'b1, 16'h017C, 10, 1'b1, 1'b1, 16'h017C, 1'b0, 1'b1);

      checkOutput("sb_empty", 16'(sbq.size()), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
